// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
//
// Turns the four raw board buttons into the LED display configuration.
// Each button is synchronised (2 flops), debounced and rising-edge detected.
// A small FSM holds the active one-hot colour. A separate toggle bit holds the
// working mode. Every output is registered, so there is no combinational path
// from i_btn to any output.
//
// Ports
//   clock     in   1       system clock, rising edge
//   i_reset   in   1       asynchronous active-low reset
//   i_btn     in   NB_BTN  raw button levels, 1 = pressed
//                          (btn0 mode, btn1 red, btn2 green, btn3 blue)
//   o_mode    out  1       0 = shift-register pattern, 1 = flash pattern
//   o_color   out  3       one-hot {b,g,r}; 3'b000 = dark
//   o_update  out  1       one-cycle pulse when o_mode/o_color take a new value
//   o_press   out  NB_BTN  one-cycle pulse per accepted (debounced) press
//
// The FSM state encoding is the colour code itself, so o_color is the state
// register and the FSM state is always observable on that port.
// -----------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter int NB_BTN    = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int NB_DB     = 20
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic              o_mode,
    output logic [2:0]        o_color,
    output logic              o_update,
    output logic [NB_BTN-1:0] o_press
);

    localparam logic [NB_DB-1:0] CNT_LAST = NB_DB'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_DARK  = 3'b000,
        ST_RED   = 3'b001,
        ST_GREEN = 3'b010,
        ST_BLUE  = 3'b100
    } state_t;

    logic [NB_BTN-1:0] sync_1;
    logic [NB_BTN-1:0] sync_2;
    logic [NB_BTN-1:0] db_state;
    logic [NB_DB-1:0]  cnt [NB_BTN];
    logic [NB_BTN-1:0] rise;

    state_t state;
    state_t state_nxt;
    logic   mode_nxt;
    logic   update_nxt;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= i_btn;
            sync_2 <= sync_1;
        end
    end

    // Debouncer: a level change is accepted only after DB_CYCLES consecutive
    // samples that differ from the accepted level. Any sample that matches the
    // accepted level restarts the count.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            db_state <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_BTN; i++) begin
                if (sync_2[i] == db_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db_state[i] <= sync_2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // The 0->1 acceptance is detected on the same edge that updates db_state.
    // This makes the registered press pulse coincide with the new debounced level.
    always_comb begin
        rise = '0;
        for (int i = 0; i < NB_BTN; i++) begin
            rise[i] = sync_2[i] & ~db_state[i] & (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_press <= '0;
        end else begin
            o_press <= rise;
        end
    end

    // Config FSM next state. Red beats green, and green beats blue. DARK is
    // only reachable through reset. The mode toggle is independent of the
    // colour change.
    always_comb begin
        state_nxt  = state;
        mode_nxt   = o_mode ^ o_press[0];
        update_nxt = 1'b0;
        if (o_press[1]) begin
            state_nxt = ST_RED;
        end else if (o_press[2]) begin
            state_nxt = ST_GREEN;
        end else if (o_press[3]) begin
            state_nxt = ST_BLUE;
        end
        update_nxt = (state_nxt != state) || (mode_nxt != o_mode);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_DARK;
            o_mode   <= 1'b0;
            o_update <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_mode   <= mode_nxt;
            o_update <= update_nxt;
        end
    end

    assign o_color = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
//
// Directed test of led_mode_ctrl with DB_CYCLES=4. The reference model keeps a
// sliding window of the last DB_CYCLES synchronised samples per button. It
// accepts a new level when the whole window disagrees with the current level.
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;

    localparam int NB_BTN = 4;
    localparam int DB     = 4;
    localparam int NB_DB  = 3;

    logic              clock;
    logic              i_reset;
    logic [NB_BTN-1:0] i_btn;
    logic              o_mode;
    logic [2:0]        o_color;
    logic              o_update;
    logic [NB_BTN-1:0] o_press;

    int n_vec;
    int n_bad;

    led_mode_ctrl #(.NB_BTN(NB_BTN), .DB_CYCLES(DB), .NB_DB(NB_DB)) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_btn    (i_btn),
        .o_mode   (o_mode),
        .o_color  (o_color),
        .o_update (o_update),
        .o_press  (o_press)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [NB_BTN-1:0] m_raw1  = '0;
    logic [NB_BTN-1:0] m_raw2  = '0;
    logic [NB_BTN-1:0] m_hist [DB];
    logic [NB_BTN-1:0] m_deb   = '0;
    logic [NB_BTN-1:0] m_press = '0;
    logic              m_mode  = 1'b0;
    logic [2:0]        m_color = 3'b000;
    logic              m_upd   = 1'b0;
    logic [3:0]        exp_q [$];

    initial begin
        for (int k = 0; k < DB; k++) m_hist[k] = '0;
    end

    always @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            m_raw1 = '0; m_raw2 = '0; m_deb = '0; m_press = '0;
            m_mode = 1'b0; m_color = 3'b000; m_upd = 1'b0;
            for (int k = 0; k < DB; k++) m_hist[k] = '0;
            exp_q.delete();
        end else begin
            logic [2:0]        nc;
            logic              nm;
            logic [NB_BTN-1:0] np;
            logic              all_diff;
            nc = m_color;
            if (m_press[1])      nc = 3'b001;
            else if (m_press[2]) nc = 3'b010;
            else if (m_press[3]) nc = 3'b100;
            nm = m_mode ^ m_press[0];
            m_upd = (nc != m_color) || (nm != m_mode);
            if (m_upd) exp_q.push_back({nm, nc});
            m_color = nc;
            m_mode  = nm;
            for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_raw2;
            m_raw2 = m_raw1;
            m_raw1 = i_btn;
            np = '0;
            for (int b = 0; b < NB_BTN; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    np[b]    = ~m_deb[b];
                    m_deb[b] = ~m_deb[b];
                end
            end
            m_press = np;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs sampled on the falling edge every cycle.
    always @(negedge clock) begin
        check("mode",   32'(o_mode),   32'(m_mode));
        check("color",  32'(o_color),  32'(m_color));
        check("update", 32'(o_update), 32'(m_upd));
        check("press",  32'(o_press),  32'(m_press));
        if (o_update === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_update", 32'(1), 32'(0));
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("sb_update_value", 32'({o_mode, o_color}), 32'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Raise the buttons in mask on a falling edge. Hold them for 'hold' rising
    // edges, then release. The task watches at least 20 edges, and records the
    // edge of the first o_press and of the first o_update, counted from the
    // first edge that samples the button high.
    task automatic press_watch(input string name, input logic [3:0] mask, input int hold,
                               input int exp_press_edge, input int exp_upd_edge,
                               input logic [2:0] exp_c, input logic exp_m);
        int watch;
        int press_edge;
        int upd_edge;
        int upd_cnt;
        watch = (hold > 20) ? hold : 20;
        press_edge = 0; upd_edge = 0; upd_cnt = 0;
        i_btn = i_btn | mask;
        for (int e = 1; e <= watch; e++) begin
            @(posedge clock); #1;
            if (o_press != '0 && press_edge == 0) press_edge = e;
            if (o_update) begin
                upd_cnt++;
                if (upd_edge == 0) upd_edge = e;
            end
            if (e == hold) begin
                @(negedge clock);
                i_btn = i_btn & ~mask;
            end
        end
        @(negedge clock);
        tick(2 * DB + 6);
        check({name, "_press_edge"}, 32'(press_edge), 32'(exp_press_edge));
        check({name, "_upd_edge"},   32'(upd_edge),   32'(exp_upd_edge));
        check({name, "_upd_count"},  32'(upd_cnt),    32'((exp_upd_edge != 0) ? 1 : 0));
        check({name, "_color"},      32'(o_color),    32'(exp_c));
        check({name, "_mode"},       32'(o_mode),     32'(exp_m));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bounce_press;
        n_vec = 0;
        n_bad = 0;
        i_btn = '0;
        i_reset = 1'b1;
        #1 i_reset = 1'b0;
        tick(3);
        check("reset_out", 32'({o_mode, o_color, o_update, o_press}), 32'(0));
        i_reset = 1'b1;
        tick(2);

        // Bounce: 3 high / 1 low for 40 cycles must not be accepted.
        bounce_press = 0;
        for (int r = 0; r < 10; r++) begin
            i_btn[2] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                if (o_press[2]) bounce_press++;
            end
            i_btn[2] = 1'b0;
            tick(1);
            if (o_press[2]) bounce_press++;
        end
        check("bounce_no_press", 32'(bounce_press), 32'(0));
        press_watch("green", 4'b0100, 20, 6, 7, 3'b010, 1'b0);

        // Long hold of the mode button gives exactly one toggle.
        press_watch("hold_mode", 4'b0001, 200, 6, 7, 3'b010, 1'b1);

        // Reset in the middle of a btn1 bounce, with btn1 held through release.
        i_btn[1] = 1'b1; tick(3);
        i_btn[1] = 1'b0; tick(1);
        i_btn[1] = 1'b1; tick(2);
        #2 i_reset = 1'b0;
        #1 check("async_reset", 32'({o_mode, o_color, o_update, o_press}), 32'(0));
        tick(3);
        i_reset = 1'b1;
        press_watch("red_after_rst", 4'b0010, 20, 6, 7, 3'b001, 1'b0);

        // Mode toggles 0->1 and then 1->0.
        press_watch("mode_on",  4'b0001, 20, 6, 7, 3'b001, 1'b1);
        press_watch("mode_off", 4'b0001, 20, 6, 7, 3'b001, 1'b0);

        // All buttons at once: red wins, and the mode toggles in the same update.
        press_watch("blue", 4'b1000, 20, 6, 7, 3'b100, 1'b0);
        press_watch("simul", 4'b1111, 20, 6, 7, 3'b001, 1'b1);

        // Pressing the active colour again gives a press pulse and no update.
        press_watch("blue2", 4'b1000, 20, 6, 7, 3'b100, 1'b1);
        press_watch("redundant", 4'b1000, 20, 6, 0, 3'b100, 1'b1);

        // A glitch one sample short of the debounce window is ignored.
        press_watch("glitch", 4'b1000, DB - 1, 0, 0, 3'b100, 1'b1);

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
